// File: rtl/rx_frame_filter.sv
// rtl/rx_frame_filter.sv - receive header parser: address filter, header capture, gated FIFO write stream
module rx_frame_filter #(
    parameter logic [7:0]  MAC_ADDR   = 8'h61,
    parameter logic [7:0]  BCAST_ADDR = 8'h2A,
    parameter int unsigned MAX_LEN    = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       cardet_in,
    input  logic       rx_error,
    output logic       write,
    output logic [7:0] wdata,
    output logic       cardet_out,
    output logic [7:0] pkt_type,
    output logic [7:0] src_addr,
    output logic [7:0] byte_count,
    output logic       drop_pulse,
    output logic       abort_pulse
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DEST    = 3'd1,
        SRC     = 3'd2,
        TYPE    = 3'd3,
        PAYLOAD = 3'd4,
        FLUSH   = 3'd5,
        DROP    = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic       write_q, write_d;
    logic [7:0] wdata_q, wdata_d;
    logic       cardet_q, cardet_d;
    logic [7:0] pkt_type_q, pkt_type_d;
    logic [7:0] src_addr_q, src_addr_d;
    logic [7:0] count_q, count_d;
    logic       drop_q, drop_d;
    logic       abort_q, abort_d;

    logic addr_match;
    assign addr_match = (rx_data == MAC_ADDR) || (rx_data == BCAST_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            wdata_q    <= 8'd0;
            cardet_q   <= 1'b0;
            pkt_type_q <= 8'd0;
            src_addr_q <= 8'd0;
            count_q    <= 8'd0;
            drop_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            cardet_q   <= cardet_d;
            pkt_type_q <= pkt_type_d;
            src_addr_q <= src_addr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            abort_q    <= abort_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        write_d    = 1'b0;
        wdata_d    = wdata_q;
        cardet_d   = cardet_q;
        pkt_type_d = pkt_type_q;
        src_addr_d = src_addr_q;
        count_d    = count_q;
        drop_d     = 1'b0;
        abort_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cardet_d = 1'b0;
                if (cardet_in) begin
                    state_d = DEST;
                    count_d = 8'd0;
                end
            end

            DEST: begin
                if (rx_error) begin
                    state_d = DROP;
                end else if (rx_valid) begin
                    if (addr_match) begin
                        write_d  = 1'b1;
                        wdata_d  = rx_data;
                        cardet_d = 1'b1;
                        count_d  = 8'd1;
                        state_d  = SRC;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = DROP;
                    end
                end else if (!cardet_in) begin
                    state_d = IDLE;
                end
            end

            // A byte arriving with the carrier fall is taken first; the runt is seen next cycle.
            SRC, TYPE: begin
                if (rx_error) begin
                    abort_d  = 1'b1;
                    cardet_d = 1'b0;
                    state_d  = DROP;
                end else if (rx_valid) begin
                    write_d = 1'b1;
                    wdata_d = rx_data;
                    count_d = count_q + 8'd1;
                    if (state_q == SRC) begin
                        src_addr_d = rx_data;
                        state_d    = TYPE;
                    end else begin
                        pkt_type_d = rx_data;
                        state_d    = PAYLOAD;
                    end
                end else if (!cardet_in) begin
                    abort_d  = 1'b1;
                    cardet_d = 1'b0;
                    state_d  = IDLE;
                end
            end

            PAYLOAD: begin
                if (rx_error) begin
                    abort_d  = 1'b1;
                    cardet_d = 1'b0;
                    state_d  = DROP;
                end else if (rx_valid && (count_q >= MAX_LEN_B)) begin
                    abort_d  = 1'b1;
                    cardet_d = 1'b0;
                    state_d  = DROP;
                end else begin
                    if (rx_valid) begin
                        write_d = 1'b1;
                        wdata_d = rx_data;
                        count_d = count_q + 8'd1;
                    end
                    // Going straight to FLUSH keeps the carrier fall exactly one cycle behind a coincident last write.
                    if (!cardet_in) begin
                        state_d = FLUSH;
                    end
                end
            end

            FLUSH: begin
                cardet_d = 1'b0;
                state_d  = IDLE;
            end

            DROP: begin
                cardet_d = 1'b0;
                if (!cardet_in) begin
                    state_d = IDLE;
                end
            end

            default: begin
                cardet_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign write       = write_q;
    assign wdata       = wdata_q;
    assign cardet_out  = cardet_q;
    assign pkt_type    = pkt_type_q;
    assign src_addr    = src_addr_q;
    assign byte_count  = count_q;
    assign drop_pulse  = drop_q;
    assign abort_pulse = abort_q;

endmodule

// File: tb/tb_rx_frame_filter.sv
// tb/tb_rx_frame_filter.sv - scoreboard bench for rx_frame_filter
module tb_rx_frame_filter;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cardet_in;
    logic       rx_error;
    logic       write;
    logic [7:0] wdata;
    logic       cardet_out;
    logic [7:0] pkt_type;
    logic [7:0] src_addr;
    logic [7:0] byte_count;
    logic       drop_pulse;
    logic       abort_pulse;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int wr_cnt = 0, drop_cnt = 0, abort_cnt = 0, rise_cnt = 0;
    int cyc_n = 0, last_write_cyc = -100, fall_cyc = -100;
    logic prev_cardet = 1'b0;

    rx_frame_filter #(
        .MAC_ADDR  (8'h61),
        .BCAST_ADDR(8'h2A),
        .MAX_LEN   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cardet_in  (cardet_in),
        .rx_error   (rx_error),
        .write      (write),
        .wdata      (wdata),
        .cardet_out (cardet_out),
        .pkt_type   (pkt_type),
        .src_addr   (src_addr),
        .byte_count (byte_count),
        .drop_pulse (drop_pulse),
        .abort_pulse(abort_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n++;

    // Output monitor: pops the scoreboard on every write and tracks pulses and carrier edges.
    always @(negedge clk) begin
        if (write) begin
            wr_cnt++;
            last_write_cyc = cyc_n;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got wdata=%02h, required no write", wdata);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (wdata !== e) begin
                    errors++;
                    $display("FAIL wdata: got %02h, required %02h", wdata, e);
                end
            end
            checks++;
            if (cardet_out !== 1'b1) begin
                errors++;
                $display("FAIL cardet_during_write: got %b, required 1", cardet_out);
            end
        end
        if (drop_pulse) drop_cnt++;
        if (abort_pulse) begin
            abort_cnt++;
            checks++;
            if (cardet_out !== 1'b0) begin
                errors++;
                $display("FAIL cardet_on_abort: got %b, required 0", cardet_out);
            end
        end
        if (cardet_out && !prev_cardet) begin
            rise_cnt++;
            checks++;
            if (write !== 1'b1) begin
                errors++;
                $display("FAIL cardet_rise_with_write: write=%b, required 1", write);
            end
        end
        if (!cardet_out && prev_cardet) begin
            fall_cyc = cyc_n;
            checks++;
            if (fall_cyc <= last_write_cyc) begin
                errors++;
                $display("FAIL cardet_fall_after_write: fall cycle %0d, last write cycle %0d, required later", fall_cyc, last_write_cyc);
            end
        end
        prev_cardet = cardet_out;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b, input bit exp);
        rx_valid = 1'b1;
        rx_data  = b;
        if (exp) exp_q.push_back(b);
        tick(1);
        rx_valid = 1'b0;
        tick(1);
    endtask

    task automatic start_frame();
        cardet_in = 1'b1;
        tick(1);
    endtask

    task automatic end_frame();
        cardet_in = 1'b0;
        tick(4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if ({write, wdata, cardet_out, pkt_type, src_addr, byte_count, drop_pulse, abort_pulse} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state: got w=%b wd=%02h co=%b pt=%02h sa=%02h bc=%0d dp=%b ap=%b, required all 0",
                     write, wdata, cardet_out, pkt_type, src_addr, byte_count, drop_pulse, abort_pulse);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_unicast();
        int w0;
        w0 = wr_cnt;
        start_frame();
        put(8'h61, 1); put(8'h62, 1); put(8'h31, 1); put(8'hAA, 1); put(8'hBB, 1);
        end_frame();
        checks++;
        if (wr_cnt - w0 !== 5) begin errors++; $display("FAIL unicast_writes: got %0d, required 5", wr_cnt - w0); end
        checks++;
        if (pkt_type !== 8'h31) begin errors++; $display("FAIL unicast_pkt_type: got %02h, required 31", pkt_type); end
        checks++;
        if (src_addr !== 8'h62) begin errors++; $display("FAIL unicast_src_addr: got %02h, required 62", src_addr); end
        checks++;
        if (byte_count !== 8'd5) begin errors++; $display("FAIL unicast_byte_count: got %0d, required 5", byte_count); end
        checks++;
        if (cardet_out !== 1'b0) begin errors++; $display("FAIL unicast_cardet_end: got %b, required 0", cardet_out); end
    endtask

    task automatic test_broadcast_mismatch();
        int w0, d0, r0;
        start_frame();
        put(8'h2A, 1); put(8'h55, 1); put(8'h07, 1); put(8'hC3, 1);
        end_frame();
        checks++;
        if (pkt_type !== 8'h07 || src_addr !== 8'h55 || byte_count !== 8'd4) begin
            errors++;
            $display("FAIL bcast_capture: got pt=%02h sa=%02h bc=%0d, required 07 55 4", pkt_type, src_addr, byte_count);
        end
        w0 = wr_cnt; d0 = drop_cnt; r0 = rise_cnt;
        start_frame();
        put(8'h63, 0); put(8'h64, 0); put(8'h65, 0);
        end_frame();
        checks++;
        if (drop_cnt - d0 !== 1) begin errors++; $display("FAIL mismatch_drop: got %0d pulses, required 1", drop_cnt - d0); end
        checks++;
        if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL mismatch_writes: got %0d, required 0", wr_cnt - w0); end
        checks++;
        if (rise_cnt - r0 !== 0) begin errors++; $display("FAIL mismatch_cardet: got %0d rises, required 0", rise_cnt - r0); end
        checks++;
        if (pkt_type !== 8'h07 || src_addr !== 8'h55) begin
            errors++;
            $display("FAIL mismatch_hold: got pt=%02h sa=%02h, required 07 55", pkt_type, src_addr);
        end
    endtask

    task automatic test_runt();
        int w0, a0;
        w0 = wr_cnt; a0 = abort_cnt;
        start_frame();
        put(8'h61, 1); put(8'h62, 1);
        end_frame();
        checks++;
        if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL runt_writes: got %0d, required 2", wr_cnt - w0); end
        checks++;
        if (abort_cnt - a0 !== 1) begin errors++; $display("FAIL runt_abort: got %0d, required 1", abort_cnt - a0); end
        checks++;
        if (cardet_out !== 1'b0 || pkt_type !== 8'h07) begin
            errors++;
            $display("FAIL runt_state: got co=%b pt=%02h, required 0 07", cardet_out, pkt_type);
        end
        w0 = wr_cnt;
        start_frame();
        put(8'h2A, 1); put(8'h11, 1); put(8'h22, 1); put(8'h33, 1);
        end_frame();
        checks++;
        if (wr_cnt - w0 !== 4 || pkt_type !== 8'h22 || byte_count !== 8'd4) begin
            errors++;
            $display("FAIL after_runt: got writes=%0d pt=%02h bc=%0d, required 4 22 4", wr_cnt - w0, pkt_type, byte_count);
        end
    endtask

    task automatic test_overflow();
        int w0, a0;
        w0 = wr_cnt; a0 = abort_cnt;
        start_frame();
        for (int i = 0; i < 10; i++) begin
            logic [7:0] b;
            b = (i == 0) ? 8'h61 : 8'(8'h80 + i);
            put(b, i < 8);
        end
        end_frame();
        checks++;
        if (wr_cnt - w0 !== 8) begin errors++; $display("FAIL overflow_writes: got %0d, required 8", wr_cnt - w0); end
        checks++;
        if (abort_cnt - a0 !== 1) begin errors++; $display("FAIL overflow_abort: got %0d, required 1", abort_cnt - a0); end
        checks++;
        if (byte_count !== 8'd8) begin errors++; $display("FAIL overflow_byte_count: got %0d, required 8", byte_count); end
    endtask

    task automatic test_coincident_end();
        int w0;
        w0 = wr_cnt;
        start_frame();
        put(8'h61, 1); put(8'h62, 1); put(8'h33, 1);
        rx_valid  = 1'b1;
        rx_data   = 8'h44;
        cardet_in = 1'b0;
        exp_q.push_back(8'h44);
        tick(1);
        rx_valid = 1'b0;
        tick(4);
        checks++;
        if (wr_cnt - w0 !== 4 || byte_count !== 8'd4) begin
            errors++;
            $display("FAIL coincident_writes: got writes=%0d bc=%0d, required 4 4", wr_cnt - w0, byte_count);
        end
        checks++;
        if (fall_cyc - last_write_cyc !== 1) begin
            errors++;
            $display("FAIL coincident_fall: got fall %0d cycles after write, required 1", fall_cyc - last_write_cyc);
        end
    endtask

    task automatic test_rx_error();
        int w0, a0;
        w0 = wr_cnt; a0 = abort_cnt;
        start_frame();
        put(8'h61, 1); put(8'h62, 1); put(8'h35, 1); put(8'hAA, 1);
        rx_error = 1'b1;
        put(8'hBB, 0);
        rx_error = 1'b0;
        put(8'hCC, 0);
        end_frame();
        checks++;
        if (wr_cnt - w0 !== 4) begin errors++; $display("FAIL rxerr_writes: got %0d, required 4", wr_cnt - w0); end
        checks++;
        if (abort_cnt - a0 !== 1) begin errors++; $display("FAIL rxerr_abort: got %0d, required 1", abort_cnt - a0); end
        checks++;
        if (byte_count !== 8'd4 || pkt_type !== 8'h35 || cardet_out !== 1'b0) begin
            errors++;
            $display("FAIL rxerr_state: got bc=%0d pt=%02h co=%b, required 4 35 0", byte_count, pkt_type, cardet_out);
        end
    endtask

    task automatic test_reset_midframe();
        start_frame();
        put(8'h61, 1); put(8'h77, 1); put(8'h88, 1); put(8'h99, 1);
        reset     = 1'b1;
        cardet_in = 1'b0;
        tick(1);
        checks++;
        if ({write, wdata, cardet_out, pkt_type, src_addr, byte_count, drop_pulse, abort_pulse} !== 35'd0) begin
            errors++;
            $display("FAIL midframe_reset: got w=%b wd=%02h co=%b pt=%02h sa=%02h bc=%0d, required all 0",
                     write, wdata, cardet_out, pkt_type, src_addr, byte_count);
        end
        reset = 1'b0;
        tick(2);
        start_frame();
        put(8'h2A, 1); put(8'h12, 1); put(8'h34, 1); put(8'h56, 1);
        end_frame();
        checks++;
        if (pkt_type !== 8'h34 || src_addr !== 8'h12 || byte_count !== 8'd4) begin
            errors++;
            $display("FAIL after_reset_frame: got pt=%02h sa=%02h bc=%0d, required 34 12 4", pkt_type, src_addr, byte_count);
        end
    endtask

    initial begin
        reset     = 1'b1;
        rx_data   = 8'd0;
        rx_valid  = 1'b0;
        cardet_in = 1'b0;
        rx_error  = 1'b0;
        test_reset();
        test_unicast();
        test_broadcast_mismatch();
        test_runt();
        test_overflow();
        test_coincident_end();
        test_rx_error();
        test_reset_midframe();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
